lcd_stream_gen: RTL and testbench

LCD_STREAM_GEN -- requirements
Module: lcd_stream_gen

---
 rtl/gb_lcd_pkg.sv | 25 ++
 rtl/lcd_stream_gen.sv | 182 ++++++++++++++++++
 tb/tb_lcd_stream_gen.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_lcd_pkg.sv
// Shared definitions for the LCD pixel stream generator.
// State encoding, counter types and default panel timing.
package gb_lcd_pkg;

  localparam int DEF_LINE_PIXELS = 160;
  localparam int DEF_FRAME_LINES = 144;
  localparam int DEF_LATCH_HIGH  = 1;
  localparam int DEF_LATCH_LOW   = 1;
  localparam int DEF_HSYNC_WIDTH = 2;
  localparam int DEF_VSYNC_WIDTH = 4;

  localparam int CNT_W = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_LATCH = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HSYNC = 3'd5
  } lcd_state_e;

endpackage

// File: rtl/lcd_stream_gen.sv
// Converts a PPU pixel stream into LCD strobes and sync pulses.
// Every output is a flop; pix_ready follows the next state.
module lcd_stream_gen
  import gb_lcd_pkg::*;
#(
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int FRAME_LINES = DEF_FRAME_LINES,
  parameter int LATCH_HIGH  = DEF_LATCH_HIGH,
  parameter int LATCH_LOW   = DEF_LATCH_LOW,
  parameter int HSYNC_WIDTH = DEF_HSYNC_WIDTH,
  parameter int VSYNC_WIDTH = DEF_VSYNC_WIDTH
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] pix_in,
  input  logic       pix_sof,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [1:0] pixel_data,
  output logic       data_latch,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_done,
  output logic       sync_error
);

  // Phase limits are "last cycle" values; all widths must be >= 1.
  localparam cnt_t VS_LAST   = cnt_t'(VSYNC_WIDTH - 1);
  localparam cnt_t LH_LAST   = cnt_t'(LATCH_HIGH - 1);
  localparam cnt_t LL_LAST   = cnt_t'(LATCH_LOW - 1);
  localparam cnt_t HS_LAST   = cnt_t'(HSYNC_WIDTH - 1);
  localparam cnt_t PIX_LAST  = cnt_t'(LINE_PIXELS - 1);
  localparam cnt_t LINE_LAST = cnt_t'(FRAME_LINES - 1);
  localparam cnt_t ONE       = cnt_t'(1);

  lcd_state_e state_q, state_d;
  cnt_t       phase_q, phase_d;
  cnt_t       pix_cnt_q, pix_cnt_d;
  cnt_t       line_cnt_q, line_cnt_d;
  logic [1:0] data_q, data_d;
  logic       ready_q, ready_d;
  logic       latch_q, latch_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fdone_q, fdone_d;
  logic       serr_q, serr_d;
  logic       xfer;

  assign xfer = pix_valid & ready_q;

  // State, counters and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      data_q     <= 2'b00;
      ready_q    <= 1'b0;
      latch_q    <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      fdone_q    <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      latch_q    <= latch_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      fdone_q    <= fdone_d;
      serr_q     <= serr_d;
    end
  end

  // Next state, counters, captured pixel and event pulses.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    data_d     = data_q;
    fdone_d    = 1'b0;
    serr_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer && pix_sof) begin
          data_d     = pix_in;
          phase_d    = '0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          state_d    = ST_VSYNC;
        end
      end
      ST_VSYNC: begin
        if (phase_q == VS_LAST) begin
          phase_d = '0;
          state_d = ST_LATCH;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_LATCH: begin
        if (phase_q == LH_LAST) begin
          phase_d = '0;
          state_d = ST_GAP;
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_GAP: begin
        if (phase_q == LL_LAST) begin
          phase_d = '0;
          if (pix_cnt_q == PIX_LAST) begin
            pix_cnt_d = '0;
            state_d   = ST_HSYNC;
          end else begin
            pix_cnt_d = pix_cnt_q + ONE;
            state_d   = ST_WAIT;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      ST_WAIT: begin
        if (xfer) begin
          data_d  = pix_in;
          phase_d = '0;
          if (pix_sof) begin
            serr_d     = 1'b1;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            state_d    = ST_VSYNC;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_HSYNC: begin
        if (phase_q == HS_LAST) begin
          phase_d   = '0;
          pix_cnt_d = '0;
          if (line_cnt_q == LINE_LAST) begin
            line_cnt_d = '0;
            fdone_d    = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            line_cnt_d = line_cnt_q + ONE;
            state_d    = ST_WAIT;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Level outputs decoded from the state being entered.
  always_comb begin
    ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
    latch_d = (state_d == ST_LATCH);
    hs_d    = (state_d == ST_HSYNC);
    vs_d    = (state_d == ST_VSYNC);
  end

  assign pix_ready  = ready_q;
  assign pixel_data = data_q;
  assign data_latch = latch_q;
  assign hsync      = hs_q;
  assign vsync      = vs_q;
  assign frame_done = fdone_q;
  assign sync_error = serr_q;

endmodule

// File: tb/tb_lcd_stream_gen.sv
// Bench for lcd_stream_gen: transaction-level model plus
// directed scenarios with literal pulse counts.
module tb_lcd_stream_gen;
  import gb_lcd_pkg::*;

  localparam int LP = 160;
  localparam int FL = 144;
  localparam int LH = 1;
  localparam int LL = 1;
  localparam int HW = 2;
  localparam int VW = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] pix_in = 2'b00;
  logic       pix_sof = 1'b0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic [1:0] pixel_data;
  logic       data_latch;
  logic       hsync;
  logic       vsync;
  logic       frame_done;
  logic       sync_error;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  lcd_stream_gen #(
    .LINE_PIXELS(LP),
    .FRAME_LINES(FL),
    .LATCH_HIGH (LH),
    .LATCH_LOW  (LL),
    .HSYNC_WIDTH(HW),
    .VSYNC_WIDTH(VW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pix_in    (pix_in),
    .pix_sof   (pix_sof),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pixel_data(pixel_data),
    .data_latch(data_latch),
    .hsync     (hsync),
    .vsync     (vsync),
    .frame_done(frame_done),
    .sync_error(sync_error)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected output vector for one cycle.
  typedef struct packed {
    logic       rdy;
    logic [1:0] dat;
    logic       lat;
    logic       hs;
    logic       vs;
    logic       fd;
    logic       se;
  } ov_t;

  ov_t        q[$];
  ov_t        cur;
  bit         in_frame;
  bit         fd_pend;
  int         pcnt;
  int         lcnt;
  logic [1:0] mdat;

  int         cyc = 0;
  int         shown = 0;
  int         n_lat = 0, n_hs = 0, n_vs = 0, n_fd = 0, n_se = 0;
  int         c_hs = 0, c_vs = 0;
  logic [1:0] lat_val[$];
  int         lat_cyc[$];
  logic       p_lat = 1'b0, p_hs = 1'b0, p_vs = 1'b0;

  function automatic ov_t mk(bit lat, bit hs, bit vs, bit se);
    ov_t o;
    o     = '0;
    o.dat = mdat;
    o.lat = lat;
    o.hs  = hs;
    o.vs  = vs;
    o.se  = se;
    return o;
  endfunction

  // One displayed pixel: strobe, gap, and line/frame bookkeeping.
  task automatic m_pixel();
    for (int i = 0; i < LH; i++) q.push_back(mk(1, 0, 0, 0));
    for (int i = 0; i < LL; i++) q.push_back(mk(0, 0, 0, 0));
    pcnt++;
    if (pcnt == LP) begin
      pcnt = 0;
      for (int i = 0; i < HW; i++) q.push_back(mk(0, 1, 0, 0));
      lcnt++;
      if (lcnt == FL) begin
        lcnt     = 0;
        in_frame = 0;
        fd_pend  = 1;
      end
    end
  endtask

  task automatic m_accept(input logic [1:0] p, input logic s);
    bit se;
    se = in_frame;
    if (s) begin
      mdat     = p;
      pcnt     = 0;
      lcnt     = 0;
      in_frame = 1;
      for (int i = 0; i < VW; i++) q.push_back(mk(0, 0, 1, se && i == 0));
      m_pixel();
    end else if (in_frame) begin
      mdat = p;
      m_pixel();
    end
  endtask

  // Model advance at each edge, compare 1 ns later, then count pulses.
  initial begin
    logic [7:0] act;
    cur = '0;
    forever begin
      @(posedge clock);
      if (!reset_n) begin
        q.delete();
        cur      = '0;
        in_frame = 0;
        fd_pend  = 0;
        pcnt     = 0;
        lcnt     = 0;
        mdat     = 2'b00;
      end else begin
        if (cur.rdy && pix_valid) m_accept(pix_in, pix_sof);
        if (q.size() > 0) begin
          cur = q.pop_front();
        end else begin
          cur     = '0;
          cur.rdy = 1'b1;
          cur.dat = mdat;
          cur.fd  = fd_pend;
          fd_pend = 0;
        end
      end
      #1;
      cyc++;
      act = {pix_ready, pixel_data, data_latch,
             hsync, vsync, frame_done, sync_error};
      checks++;
      if (act !== cur) begin
        errors++;
        if (shown < 20)
          $display("FAIL cycle_outputs cyc %0d got %b expected %b",
                   cyc, act, cur);
        shown++;
      end
      if (data_latch && !p_lat) begin
        n_lat++;
        lat_val.push_back(pixel_data);
        lat_cyc.push_back(cyc);
      end
      if (hsync && !p_hs) n_hs++;
      if (vsync && !p_vs) n_vs++;
      if (hsync) c_hs++;
      if (vsync) c_vs++;
      if (frame_done) n_fd++;
      if (sync_error) n_se++;
      p_lat = data_latch;
      p_hs  = hsync;
      p_vs  = vsync;
    end
  end

  // Present a pixel at a falling edge and hold it until accepted.
  task automatic send(input logic [1:0] p, input logic s);
    int n;
    n         = 0;
    pix_valid = 1'b1;
    pix_in    = p;
    pix_sof   = s;
    while (!pix_ready && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) chk("send_timeout", n, 0);
    @(negedge clock);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b_lat, b_hs, b_vs, b_fd, b_se, b_vc, b_hc, b_q;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_ready", int'(pix_ready), 0);
    chk("reset_outputs", int'({pixel_data, data_latch, hsync,
                               vsync, frame_done, sync_error}), 0);
    reset_n = 1'b1;
    #1;
    chk("ready_before_edge", int'(pix_ready), 0);
    @(negedge clock);
    chk("ready_after_edge", int'(pix_ready), 1);

    b_lat = n_lat;
    b_vs  = n_vs;
    for (int i = 0; i < 5; i++) send(2'(i + 1), 1'b0);
    repeat (3) @(negedge clock);
    chk("idle_drop_latch", n_lat - b_lat, 0);
    chk("idle_drop_vsync", n_vs - b_vs, 0);
    chk("idle_ready", int'(pix_ready), 1);

    b_lat = n_lat; b_hs = n_hs; b_vs = n_vs; b_fd = n_fd;
    b_se = n_se; b_vc = c_vs; b_hc = c_hs; b_q = lat_val.size();
    for (int k = 0; k < LP * FL; k++) send(2'(k), k == 0);
    repeat (6) @(negedge clock);
    chk("frame_vsync_pulses", n_vs - b_vs, 1);
    chk("frame_vsync_cycles", c_vs - b_vc, 4);
    chk("frame_latch_pulses", n_lat - b_lat, 23040);
    chk("frame_hsync_pulses", n_hs - b_hs, 144);
    chk("frame_hsync_cycles", c_hs - b_hc, 288);
    chk("frame_done_pulses", n_fd - b_fd, 1);
    chk("frame_sync_errors", n_se - b_se, 0);
    for (int i = 0; i < 4; i++)
      chk("first_pixels", int'(lat_val[b_q + i]), i);
    chk("pixel_period", lat_cyc[b_q + 2] - lat_cyc[b_q + 1], 3);

    b_hs = n_hs;
    send(2'd3, 1'b1);
    for (int k = 1; k < 20; k++) send(2'(3 - k), 1'b0);
    b_lat = n_lat;
    repeat (10) @(negedge clock);
    chk("stall_no_latch", n_lat - b_lat, 0);
    for (int k = 20; k < LP; k++) send(2'(k), 1'b0);
    repeat (4) @(negedge clock);
    chk("stall_line_hsync", n_hs - b_hs, 1);

    for (int k = 0; k < 2 * LP + 50; k++) send(2'(k + 1), 1'b0);
    b_se = n_se; b_vs = n_vs; b_q = lat_val.size();
    send(2'b10, 1'b1);
    repeat (8) @(negedge clock);
    chk("resync_error_pulse", n_se - b_se, 1);
    chk("resync_vsync_pulse", n_vs - b_vs, 1);
    chk("resync_latch_count", lat_val.size() - b_q, 1);
    chk("resync_pixel", int'(lat_val[lat_val.size() - 1]), 2);
    b_hs = n_hs;
    for (int k = 1; k < LP; k++) send(2'(k), 1'b0);
    repeat (4) @(negedge clock);
    chk("resync_line0_hsync", n_hs - b_hs, 1);

    for (int k = 0; k < 11 * LP + 70; k++) send(2'(k), 1'b0);
    chk("midframe_in_latch", int'(data_latch), 1);
    reset_n = 1'b0;
    #1;
    chk("midframe_reset_outputs",
        int'({pix_ready, pixel_data, data_latch, hsync,
              vsync, frame_done, sync_error}), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    b_lat = n_lat; b_vs = n_vs; b_hs = n_hs;
    for (int i = 0; i < 6; i++) send(2'(i), 1'b0);
    repeat (4) @(negedge clock);
    chk("post_reset_latch", n_lat - b_lat, 0);
    chk("post_reset_vsync", n_vs - b_vs, 0);
    chk("post_reset_hsync", n_hs - b_hs, 0);
    send(2'b01, 1'b1);
    repeat (8) @(negedge clock);
    chk("post_reset_restart", n_vs - b_vs, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
